// File: rtl/sar_search.sv
// Successive-approximation search: drives probe to an external comparator, one bit decision per clock, MSB first.
// Done pulses (compares+1) cycles after the start edge; start is ignored unless idle, so nothing is queued.
module sar_search #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_equal,
  input  logic             cmp_greater,
  input  logic             cmp_less,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int IW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [IW-1:0]    IDX_MSB   = IW'(WIDTH - 1);
  localparam logic [IW-1:0]    IDX_ONE   = IW'(1);
  localparam logic [IW-1:0]    IDX_ZERO  = '0;
  localparam logic [WIDTH-1:0] PROBE_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] probe_step;
  logic             one_hot;
  logic             search_end;
  logic             search_ok;

  assign one_hot = $onehot({cmp_equal, cmp_greater, cmp_less});

  // Any malformed response, an equal, or "greater" with no bits left ends the search.
  always_comb begin
    search_end = !one_hot || cmp_equal || ((idx == IDX_ZERO) && cmp_greater);
    search_ok  = one_hot && cmp_equal;
  end

  always_comb begin
    probe_step = probe;
    if (cmp_less) begin
      probe_step[idx] = 1'b0;
    end
    if (idx != IDX_ZERO) begin
      probe_step[idx - IDX_ONE] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      probe  <= '0;
      idx    <= IDX_MSB;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SEARCH;
            probe <= PROBE_MSB;
            idx   <= IDX_MSB;
            found <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_SEARCH: begin
          if (search_end) begin
            state  <= S_FINISH;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= probe;
            found  <= search_ok;
            err    <= !search_ok;
          end else if (idx == IDX_ZERO) begin
            // Target is below the last probe: only zero remains to confirm.
            probe <= probe_step;
            state <= S_VERIFY;
          end else begin
            probe <= probe_step;
            idx   <= idx - IDX_ONE;
          end
        end
        S_VERIFY: begin
          state  <= S_FINISH;
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= probe;
          found  <= search_ok;
          err    <= !search_ok;
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a target-holding comparator model plus an arithmetic reference of the binary search.
module tb_sar_search;
  localparam int W    = 3;
  localparam int MAXV = (1 << W) - 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cmp_equal, cmp_greater, cmp_less;
  logic [W-1:0] probe, result;
  logic         busy, done, found, err;

  logic [W-1:0] target = '0;
  int           force_mode = 0;
  int           tests = 0;
  int           fails = 0;

  logic [W-1:0] seen[$];
  int           lat, done_cnt;
  logic [W-1:0] res_d, res_h;
  logic         fnd_d, err_d, fnd_h, err_h, both_seen;

  always #5 clk = ~clk;

  sar_search #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmp_equal(cmp_equal), .cmp_greater(cmp_greater), .cmp_less(cmp_less),
    .probe(probe), .busy(busy), .done(done), .found(found), .err(err), .result(result)
  );

  // mode 0: honest comparator, 1: all responses low, 2: always "greater"
  always_comb begin
    cmp_equal   = (target == probe);
    cmp_greater = (target > probe);
    cmp_less    = (target < probe);
    if (force_mode == 1) begin
      cmp_equal = 1'b0; cmp_greater = 1'b0; cmp_less = 1'b0;
    end else if (force_mode == 2) begin
      cmp_equal = 1'b0; cmp_greater = 1'b1; cmp_less = 1'b0;
    end
  end

  function automatic int exp_ncmp(input int t, input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return W;
    if (t == 0) return W + 1;
    for (int i = 0; i < W; i++) if (((t >> i) & 1) == 1) return W - i;
    return W + 1;
  endfunction

  function automatic int exp_probe(input int t, input int mode, input int j);
    int i;
    if (mode == 1) return 1 << (W - 1);
    if (mode == 2) return ((1 << (j + 1)) - 1) << (W - 1 - j);
    if (j >= W) return 0;
    i = W - 1 - j;
    return (t & ~((1 << (i + 1)) - 1)) | (1 << i);
  endfunction

  function automatic int exp_result(input int t, input int mode);
    if (mode == 1) return 1 << (W - 1);
    if (mode == 2) return MAXV;
    return t;
  endfunction

  task automatic run_search(input int t, input int mode, input int pulse_k);
    target = W'(t); force_mode = mode; seen.delete();
    lat = 0; done_cnt = 0; both_seen = 1'b0;
    res_d = 'x; res_h = 'x; fnd_d = 1'bx; err_d = 1'bx; fnd_h = 1'bx; err_h = 1'bx;
    @(negedge clk) start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy) seen.push_back(probe);
      if (found && err) both_seen = 1'b1;
      if (done) begin
        done_cnt++;
        if (lat == 0) begin lat = k; res_d = result; fnd_d = found; err_d = err; end
      end
      start = (pulse_k != 0) && (k == pulse_k);
      if (lat != 0 && k == lat + 3) begin
        res_h = result; fnd_h = found; err_h = err;
        break;
      end
    end
    start = 1'b0;
    force_mode = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({probe, busy, done, found, err, result} !== '0) begin
      fails++;
      $display("FAIL reset_state: got probe=%0d busy=%b done=%b found=%b err=%b result=%0d, want all 0",
               probe, busy, done, found, err, result);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({probe, busy, done, found, err, result} !== '0) begin
      fails++;
      $display("FAIL idle_after_reset: got probe=%0d busy=%b done=%b result=%0d, want all 0",
               probe, busy, done, result);
    end
  endtask

  task automatic test_search();
    int ct[$], cm[$];
    ct = '{5, 4, 0, 7, 4, 7, 1, 6};
    cm = '{0, 0, 0, 0, 1, 2, 2, 1};
    for (int n = 0; n < 24; n++) begin
      int r = $urandom_range(0, 9);
      ct.push_back($urandom_range(0, MAXV));
      cm.push_back(r == 8 ? 1 : (r == 9 ? 2 : 0));
    end
    foreach (ct[c]) begin
      int t = ct[c];
      int m = cm[c];
      int en = exp_ncmp(t, m);
      logic [W-1:0] er = W'(exp_result(t, m));
      logic ef = (m == 0);
      int pm = 0;
      run_search(t, m, 0);
      tests++;
      if (lat !== en + 1) begin
        fails++;
        $display("FAIL latency t=%0d mode=%0d: got %0d want %0d", t, m, lat, en + 1);
      end
      if (seen.size() != en) pm = 1;
      else foreach (seen[j]) if (seen[j] !== W'(exp_probe(t, m, j))) pm = 1;
      tests++;
      if (pm != 0) begin
        fails++;
        $display("FAIL probe_seq t=%0d mode=%0d: got %0d probes first=%0d last=%0d, want %0d probes first=%0d last=%0d",
                 t, m, seen.size(), seen.size() ? seen[0] : 0, seen.size() ? seen[$] : 0,
                 en, exp_probe(t, m, 0), exp_probe(t, m, en - 1));
      end
      tests++;
      if ({res_d, fnd_d, err_d} !== {er, ef, ~ef}) begin
        fails++;
        $display("FAIL outcome t=%0d mode=%0d: got result=%0d found=%b err=%b, want result=%0d found=%b err=%b",
                 t, m, res_d, fnd_d, err_d, er, ef, ~ef);
      end
      tests++;
      if ({res_h, fnd_h, err_h} !== {er, ef, ~ef} || done_cnt != 1 || both_seen) begin
        fails++;
        $display("FAIL hold t=%0d mode=%0d: got result=%0d found=%b err=%b dones=%0d both=%b, want result=%0d found=%b err=%b dones=1 both=0",
                 t, m, res_h, fnd_h, err_h, done_cnt, both_seen, er, ef, ~ef);
      end
    end
  endtask

  task automatic test_midsearch_reset();
    logic was_busy;
    target = '0; force_mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    was_busy = busy;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (!was_busy || probe !== '0 || busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got was_busy=%b probe=%0d busy=%b done=%b found=%b err=%b, want 1 0 0 0 0 0",
               was_busy, probe, busy, done, found, err);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_search(6, 0, 0);
    tests++;
    if (lat != 3 || res_d !== W'(6) || fnd_d !== 1'b1) begin
      fails++;
      $display("FAIL search_after_reset: got lat=%0d result=%0d found=%b, want lat=3 result=6 found=1",
               lat, res_d, fnd_d);
    end
  endtask

  task automatic test_busy_start();
    run_search(0, 0, 2);
    tests++;
    if (done_cnt != 1 || lat != W + 2 || res_d !== '0 || fnd_d !== 1'b1 || err_d !== 1'b0) begin
      fails++;
      $display("FAIL start_while_busy: got dones=%0d lat=%0d result=%0d found=%b err=%b, want 1 %0d 0 1 0",
               done_cnt, lat, res_d, fnd_d, err_d, W + 2);
    end
  endtask

  task automatic test_back_to_back();
    int dk[$];
    logic gap_busy, resume_busy;
    gap_busy = 1'bx; resume_busy = 1'bx;
    target = W'(5); force_mode = 0;
    @(negedge clk) start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) dk.push_back(k);
      if (k == 5) gap_busy = busy;
      if (k == 6) resume_busy = busy;
      if (dk.size() == 2) break;
    end
    start = 1'b0;
    tests++;
    if (dk.size() != 2 || dk[0] != 4 || dk[1] != 9) begin
      fails++;
      $display("FAIL back_to_back_done: got %0d dones first=%0d second=%0d, want 2 dones at 4 and 9",
               dk.size(), dk.size() > 0 ? dk[0] : 0, dk.size() > 1 ? dk[1] : 0);
    end
    tests++;
    if (gap_busy !== 1'b0 || resume_busy !== 1'b1) begin
      fails++;
      $display("FAIL back_to_back_gap: got idle-cycle busy=%b next busy=%b, want 0 then 1", gap_busy, resume_busy);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_search();
    test_midsearch_reset();
    test_busy_start();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
